alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle control unit that drives the registered 16-bit ALU (enable/opcode/operand side) and consumes its result and flags.
- Fetches 16-bit instructions from instruction memory through a valid handshake and decodes them.
- Issues one ALU operation per instruction, writes results back to an 8x16 register file and resolves conditional jumps from captured flags.

Parameters:
- ADDR_W, 8, program counter / instruction address width
- RST_PC, 0, program counter value after reset

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request; held until imem_valid
- imem_addr  out  ADDR_W  fetch address (= pc)
- imem_rdata  in  16  instruction word
- imem_valid  in  1  imem_rdata valid this cycle (any wait states allowed)
- alu_en  out  1  ALU enable, one-cycle pulse
- alu_op  out  5  ALU opcode
- alu_a  out  16  ALU operand a = R[rd]
- alu_b  out  16  ALU operand b = R[rs]
- alu_out  in  16  ALU result, valid the cycle after alu_en
- alu_c  in  1  ALU carry, valid the cycle after alu_en
- alu_z  in  1  ALU zero, valid the cycle after alu_en
- halted  out  1  high in HALT state
- pc  out  ADDR_W  current program counter (debug)

Behaviour:
- Instruction format: [15:11] opcode, [10:8] rd, [7:5] rs, [7:0] imm8 (LDI value / jump target).
- Reset, asynchronous: state=FETCH, pc=RST_PC, imem_req=0, alu_en=0, alu_op=0, alu_a=0, alu_b=0, halted=0, flags C/Z/N=0, registers R0..R7=0.
- FETCH: imem_req=1, imem_addr=pc. On imem_valid, latch IR, pc<=pc+1 (wraps at 2^ADDR_W), go to DECODE.
- DECODE:
  - ALU op 5'h01..5'h0A: go to EXEC.
  - NOP: go to FETCH.
  - LDI: R[rd]<=zero-extended imm8, then FETCH.
  - MOV: R[rd]<=R[rs], then FETCH.
  - JMP: pc<=imm8, then FETCH.
  - JZ/JC/JN: pc<=imm8 if the captured Z/C/N flag is 1, then FETCH.
  - HLT: go to HALT.
  - Undefined opcode: treated as NOP.
- EXEC: alu_en=1 for exactly one cycle, with alu_op=IR opcode, alu_a=R[rd], alu_b=R[rs]. Go to WB.
- WB:
  - C<=alu_c for ADD/ADC/SUB/INC/DEC/CMP; C unchanged for AND/OR/XOR/NOT.
  - Z<=alu_z.
  - N<=alu_out[15]. N is computed here, not by the ALU.
  - R[rd]<=alu_out, except for CMP (flags only).
  - Go to FETCH.
- CMP semantics: the ALU computes alu_b-alu_a (R[rs]-R[rd]); jumps test the resulting flags.
- Latency: ALU instruction = fetch + 3 cycles; LDI/MOV/NOP/jump = fetch + 1 cycle.
- HALT: absorbing state. imem_req=0, alu_en=0, halted=1. Exit only through rst.
- alu_en is never high outside EXEC. imem_req is never high outside FETCH.
- Reset asserted mid-operation (any state): immediate return to reset values, regardless of any pending imem_valid.
- Register write and read of the same register in one cycle: the read returns the old value. This cannot occur within a single instruction, because write and read happen in different states.

Decomposition:
- Shared defines (InstructionSet.v) hold the opcode encodings:
  - NOP 5'h00, ADD 01, ADC 02, SUB 03, INC 04, DEC 05, AND 06, OR 07, XOR 08, NOT 09, CMP 0A.
  - LDI 10, MOV 11, JMP 18, JZ 19, JC 1A, JN 1B, HLT 1F.
  - State encodings FETCH/DECODE/EXEC/WB/HALT.
- Sub-module reg_file: 8x16 registers, two combinational read ports, one synchronous write port, asynchronous clear on rst.

Test Plan:
- LDI R1,0x05; LDI R2,0x03; ADD R1,R2 with a model ALU -> alu_en pulses once, alu_a=5, alu_b=3, op=01; R1=0x0008, C=0, Z=0.
- LDI R1,0xFF; INC R1 with R1 preset 0xFFFF through MOV chain -> R1=0x0000, C=1, Z=1; following JZ 0x20 -> pc=0x20.
- CMP R1,R2 with R1=5, R2=5 -> R1 and R2 unchanged, Z=1; then JC 0x40 not taken -> pc increments by 1.
- imem_valid delayed 3 cycles on each fetch -> imem_req held high and imem_addr stable throughout; no ALU activity; results match the zero-wait-state run.
- AND after SUB with borrow (C=1) -> C stays 1; N=1 when the result is 0x8000.
- HLT at pc=0x07 -> halted=1, imem_req=0 forever. rst pulse during EXEC of a later program -> pc=0, all registers 0, alu_en=0 in the same cycle.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared opcodes, FSM states and decode helpers for alu_sequencer
//
// Purpose: single home for the instruction-set encodings and the sequencer
// state encoding, plus small decode helpers used by the top level.
// Ports: none (package).

package alu_sequencer_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_t;

  // Instruction word fields: [15:11] opcode, [10:8] rd, [7:5] rs, [7:0] imm8
  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 16;

  // ALU opcodes (passed straight through to the ALU)
  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_ADC = 5'h02;
  localparam logic [4:0] OP_SUB = 5'h03;
  localparam logic [4:0] OP_INC = 5'h04;
  localparam logic [4:0] OP_DEC = 5'h05;
  localparam logic [4:0] OP_AND = 5'h06;
  localparam logic [4:0] OP_OR  = 5'h07;
  localparam logic [4:0] OP_XOR = 5'h08;
  localparam logic [4:0] OP_NOT = 5'h09;
  localparam logic [4:0] OP_CMP = 5'h0A;

  // Sequencer-local opcodes (never reach the ALU)
  localparam logic [4:0] OP_LDI = 5'h10;
  localparam logic [4:0] OP_MOV = 5'h11;
  localparam logic [4:0] OP_JMP = 5'h18;
  localparam logic [4:0] OP_JZ  = 5'h19;
  localparam logic [4:0] OP_JC  = 5'h1A;
  localparam logic [4:0] OP_JN  = 5'h1B;
  localparam logic [4:0] OP_HLT = 5'h1F;

  // Opcodes 01..0A are issued to the ALU.
  function automatic logic is_alu_op(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_CMP);
  endfunction

  // Logic ops leave carry untouched; arithmetic ops and CMP update it.
  function automatic logic updates_carry(input logic [4:0] op);
    return is_alu_op(op) && !(op inside {OP_AND, OP_OR, OP_XOR, OP_NOT});
  endfunction

  // CMP only produces flags; every other ALU op writes R[rd].
  function automatic logic writes_result(input logic [4:0] op);
    return is_alu_op(op) && (op != OP_CMP);
  endfunction

endpackage

// File: rtl/alu_sequencer_reg_file.sv
// rtl/alu_sequencer_reg_file.sv - 8x16 register file, two async read ports, one sync write port
//
// Purpose: architectural registers R0..R7 of the sequencer.
// Ports:
//   clk, rst            clock, asynchronous active-high clear of all registers
//   we, waddr, wdata    synchronous write port
//   raddr_a / rdata_a   combinational read port A
//   raddr_b / rdata_b   combinational read port B
// A read and a write of the same register in one cycle returns the old value.

module alu_sequencer_reg_file
  import alu_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [2:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [0:NUM_REGS-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle fetch/decode/execute sequencer driving a registered 16-bit ALU
//
// Purpose: fetches 16-bit instructions, issues one ALU operation per ALU
// instruction, writes results back to the register file and resolves
// conditional jumps from the captured C/Z/N flags.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   imem_req/addr/rdata/valid instruction fetch handshake (req held until valid)
//   alu_en/op/a/b             ALU issue side (alu_en is a one-cycle pulse)
//   alu_out/c/z               ALU result side, valid the cycle after alu_en
//   halted                    high once HLT has been decoded
//   pc                        current program counter (debug)
// Cycle budget: ALU instruction = fetch + DECODE + EXEC + WB;
// LDI/MOV/NOP/jumps = fetch + DECODE.

module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RST_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_valid,
  output logic              alu_en,
  output logic [4:0]        alu_op,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  input  logic [15:0]       alu_out,
  input  logic              alu_c,
  input  logic              alu_z,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  state_t state;
  state_t state_nxt;

  logic [15:0] ir;
  logic        flag_c;
  logic        flag_z;
  logic        flag_n;

  logic [4:0]  ir_op;
  logic [2:0]  ir_rd;
  logic [2:0]  ir_rs;
  logic [7:0]  ir_imm;

  logic [15:0] rd_val;
  logic [15:0] rs_val;
  logic        rf_we;
  logic [15:0] rf_wdata;
  logic        jump_taken;

  assign ir_op  = ir[15:11];
  assign ir_rd  = ir[10:8];
  assign ir_rs  = ir[7:5];
  assign ir_imm = ir[7:0];

  assign imem_addr = pc;

  alu_sequencer_reg_file u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (ir_rd),
    .wdata   (rf_wdata),
    .raddr_a (ir_rd),
    .rdata_a (rd_val),
    .raddr_b (ir_rs),
    .rdata_b (rs_val)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and control outputs
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    alu_en    = 1'b0;
    alu_op    = '0;
    alu_a     = '0;
    alu_b     = '0;
    halted    = 1'b0;

    case (state)
      FETCH: begin
        // The reset state is FETCH, so the request is masked while rst is
        // still asserted to keep imem_req low during reset.
        imem_req = !rst;
        if (imem_valid) begin
          state_nxt = DECODE;
        end
      end

      DECODE: begin
        if (is_alu_op(ir_op)) begin
          state_nxt = EXEC;
        end else if (ir_op == OP_HLT) begin
          state_nxt = HALT;
        end else begin
          // LDI/MOV/jumps complete here; NOP and undefined opcodes do nothing.
          state_nxt = FETCH;
        end
      end

      EXEC: begin
        alu_en    = 1'b1;
        alu_op    = ir_op;
        alu_a     = rd_val;
        alu_b     = rs_val;
        state_nxt = WB;
      end

      WB: begin
        state_nxt = FETCH;
      end

      HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // Jump condition uses the flags captured by the most recent ALU writeback.
  always_comb begin
    jump_taken = 1'b0;
    case (ir_op)
      OP_JMP:  jump_taken = 1'b1;
      OP_JZ:   jump_taken = flag_z;
      OP_JC:   jump_taken = flag_c;
      OP_JN:   jump_taken = flag_n;
      default: jump_taken = 1'b0;
    endcase
  end

  // Register file write: LDI/MOV in DECODE, ALU result in WB.
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = alu_out;
    if (state == DECODE) begin
      if (ir_op == OP_LDI) begin
        rf_we    = 1'b1;
        rf_wdata = {8'h00, ir_imm};
      end else if (ir_op == OP_MOV) begin
        rf_we    = 1'b1;
        rf_wdata = rs_val;
      end
    end else if (state == WB) begin
      rf_we    = writes_result(ir_op);
      rf_wdata = alu_out;
    end
  end

  // Program counter, instruction register and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= ADDR_W'(RST_PC);
      ir     <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_valid) begin
            ir <= imem_rdata;
            pc <= pc + ADDR_W'(1);
          end
        end

        DECODE: begin
          if (jump_taken) begin
            pc <= ADDR_W'(ir_imm);
          end
        end

        WB: begin
          if (updates_carry(ir_op)) begin
            flag_c <= alu_c;
          end
          flag_z <= alu_z;
          // N is derived from the result sign here; the ALU does not supply it.
          flag_n <= alu_out[15];
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard testbench for alu_sequencer

module tb_alu_sequencer;

  localparam logic [4:0] O_NOP = 5'h00;
  localparam logic [4:0] O_ADD = 5'h01;
  localparam logic [4:0] O_ADC = 5'h02;
  localparam logic [4:0] O_SUB = 5'h03;
  localparam logic [4:0] O_INC = 5'h04;
  localparam logic [4:0] O_DEC = 5'h05;
  localparam logic [4:0] O_AND = 5'h06;
  localparam logic [4:0] O_OR  = 5'h07;
  localparam logic [4:0] O_XOR = 5'h08;
  localparam logic [4:0] O_NOT = 5'h09;
  localparam logic [4:0] O_CMP = 5'h0A;
  localparam logic [4:0] O_LDI = 5'h10;
  localparam logic [4:0] O_MOV = 5'h11;
  localparam logic [4:0] O_JMP = 5'h18;
  localparam logic [4:0] O_JZ  = 5'h19;
  localparam logic [4:0] O_JC  = 5'h1A;
  localparam logic [4:0] O_JN  = 5'h1B;
  localparam logic [4:0] O_HLT = 5'h1F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic        alu_en;
  logic [4:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_out;
  logic        alu_c;
  logic        alu_z;
  logic        halted;
  logic [7:0]  pc;

  always #5 clk = ~clk;

  alu_sequencer #(.ADDR_W(8), .RST_PC(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .alu_en     (alu_en),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_c      (alu_c),
    .alu_z      (alu_z),
    .halted     (halted),
    .pc         (pc)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mem [0:255];
  logic [7:0]  fetch_q [$];
  logic [36:0] alu_q [$];
  logic [36:0] alu_exp;
  bit          mon_on = 0;
  int          wait_mode = 0;
  int          wcnt = 0;
  int          wdelay = 0;
  int          exp_pc = 0;
  logic        alu_cint;
  logic [16:0] alu_r;
  logic [4:0]  undef_ops [0:5] = '{5'h0B, 5'h0F, 5'h12, 5'h17, 5'h1C, 5'h1E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference ALU arithmetic: {carry_or_borrow, result}
  function automatic logic [16:0] alu_fn(input logic [4:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin);
    case (op)
      O_ADD:   return {1'b0, a} + {1'b0, b};
      O_ADC:   return {1'b0, a} + {1'b0, b} + {16'b0, cin};
      O_SUB:   return {1'b0, a} - {1'b0, b};
      O_INC:   return {1'b0, a} + 17'd1;
      O_DEC:   return {1'b0, a} - 17'd1;
      O_AND:   return {1'b0, a & b};
      O_OR:    return {1'b0, a | b};
      O_XOR:   return {1'b0, a ^ b};
      O_NOT:   return {1'b0, ~a};
      O_CMP:   return {1'b0, b} - {1'b0, a};
      default: return 17'd0;
    endcase
  endfunction

  function automatic bit is_arith(input logic [4:0] op);
    return op inside {O_ADD, O_ADC, O_SUB, O_INC, O_DEC, O_CMP};
  endfunction

  // Registered ALU model. For logic ops it drives the inverse of the current
  // carry so that a sequencer wrongly latching C would be visible.
  always_comb alu_r = alu_fn(alu_op, alu_a, alu_b, alu_cint);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_cint <= 1'b0;
      alu_out  <= '0;
      alu_c    <= 1'b0;
      alu_z    <= 1'b0;
    end else if (alu_en) begin
      alu_out <= alu_r[15:0];
      alu_z   <= (alu_r[15:0] == 16'h0);
      if (is_arith(alu_op)) begin
        alu_c    <= alu_r[16];
        alu_cint <= alu_r[16];
      end else begin
        alu_c <= ~alu_cint;
      end
    end
  end

  // Instruction memory responder with configurable wait states
  always @(posedge clk) begin
    #1;
    if (rst || !imem_req) begin
      imem_valid = 1'b0;
      wcnt       = 0;
      wdelay     = (wait_mode == 0) ? 0 : (wait_mode == 1) ? 3 : int'($urandom_range(0, 3));
    end else if (wcnt >= wdelay) begin
      imem_valid = 1'b1;
      imem_rdata = mem[imem_addr];
    end else begin
      imem_valid = 1'b0;
      imem_rdata = 16'($urandom);
      wcnt++;
    end
  end

  // Monitor: compares every fetch request and ALU issue against the queues
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (imem_req) begin
        if (fetch_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch: got addr 0x%0h, expected no request", imem_addr);
        end else begin
          chk("fetch_addr", 32'(imem_addr), 32'(fetch_q[0]));
          if (imem_valid) void'(fetch_q.pop_front());
        end
      end
      if (alu_en) begin
        chk("alu_en_excl_req", 32'(imem_req), 32'(0));
        if (alu_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_alu: got op 0x%0h a 0x%0h b 0x%0h, expected no issue",
                   alu_op, alu_a, alu_b);
        end else begin
          alu_exp = alu_q.pop_front();
          chk("alu_op", 32'(alu_op), 32'(alu_exp[36:32]));
          chk("alu_a", 32'(alu_a), 32'(alu_exp[31:16]));
          chk("alu_b", 32'(alu_b), 32'(alu_exp[15:0]));
        end
      end
    end
  end

  // Instruction-level interpreter of the program in mem
  task automatic run_model();
    logic [15:0] r [0:7];
    logic        c, z, n;
    logic [7:0]  p;
    logic [15:0] ins;
    logic [4:0]  op;
    logic [2:0]  rd, rs;
    logic [7:0]  imm;
    logic [16:0] res;
    bit          done;
    int          steps;
    for (int i = 0; i < 8; i++) r[i] = '0;
    c = 0; z = 0; n = 0; p = 8'd0; done = 0; steps = 0;
    fetch_q.delete();
    alu_q.delete();
    while (!done && steps < 3000) begin
      fetch_q.push_back(p);
      ins = mem[p];
      p   = p + 8'd1;
      op  = ins[15:11];
      rd  = ins[10:8];
      rs  = ins[7:5];
      imm = ins[7:0];
      if (op >= O_ADD && op <= O_CMP) begin
        alu_q.push_back({op, r[rd], r[rs]});
        res = alu_fn(op, r[rd], r[rs], c);
        if (is_arith(op)) c = res[16];
        z = (res[15:0] == 16'h0);
        n = res[15];
        if (op != O_CMP) r[rd] = res[15:0];
      end else begin
        case (op)
          O_LDI:   r[rd] = {8'h00, imm};
          O_MOV:   r[rd] = r[rs];
          O_JMP:   p = imm;
          O_JZ:    if (z) p = imm;
          O_JC:    if (c) p = imm;
          O_JN:    if (n) p = imm;
          O_HLT:   done = 1;
          default: ;
        endcase
      end
      steps++;
    end
    exp_pc = int'(p);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = {O_HLT, 11'd0};
  endtask

  // OR Ri,Ri exposes every register on the ALU operand bus, then HLT.
  task automatic put_dump(input int base);
    for (int i = 0; i < 8; i++) mem[base + i] = {O_OR, 3'(i), 3'(i), 5'd0};
    mem[base + 8] = {O_HLT, 11'd0};
  endtask

  task automatic gen_random(input int len);
    logic [4:0] op;
    logic [2:0] rd;
    logic [7:0] lo;
    int         k;
    clear_mem();
    for (int p = 0; p < len; p++) begin
      k  = int'($urandom_range(0, 15));
      rd = 3'($urandom);
      lo = 8'($urandom);
      if (k <= 2)       op = O_LDI;
      else if (k == 3)  op = O_MOV;
      else if (k <= 9)  op = 5'($urandom_range(1, 10));
      else if (k == 10) op = O_NOP;
      else if (k == 11) op = undef_ops[$urandom_range(0, 5)];
      else begin
        op = 5'(O_JMP + 5'($urandom_range(0, 3)));
        lo = 8'($urandom_range(p + 1, len));
      end
      mem[p] = {op, rd, lo};
    end
    put_dump(len);
  endtask

  task automatic reset_checks();
    chk("rst_pc", 32'(pc), 32'(0));
    chk("rst_imem_req", 32'(imem_req), 32'(0));
    chk("rst_alu_en", 32'(alu_en), 32'(0));
    chk("rst_alu_op", 32'(alu_op), 32'(0));
    chk("rst_alu_a", 32'(alu_a), 32'(0));
    chk("rst_alu_b", 32'(alu_b), 32'(0));
    chk("rst_halted", 32'(halted), 32'(0));
  endtask

  task automatic run_program(input int wm, input int const_pc, input int idle);
    int cyc;
    mon_on    = 0;
    rst       = 1;
    wait_mode = wm;
    @(negedge clk);
    run_model();
    rst    = 0;
    mon_on = 1;
    cyc    = 0;
    while (halted !== 1'b1 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    chk("halt_reached", 32'(halted), 32'(1));
    repeat (idle) @(negedge clk);
    chk("final_pc_model", 32'(pc), 32'(exp_pc));
    if (const_pc >= 0) chk("final_pc_const", 32'(pc), 32'(const_pc));
    chk("fetch_q_left", 32'(fetch_q.size()), 32'(0));
    chk("alu_q_left", 32'(alu_q.size()), 32'(0));
    chk("halted_hold", 32'(halted), 32'(1));
    mon_on = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got time limit, expected summary before it");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    clear_mem();
    rst = 1;
    repeat (2) @(negedge clk);
    reset_checks();

    // LDI R1,5; LDI R2,3; ADD R1,R2
    clear_mem();
    mem[0] = {O_LDI, 3'd1, 8'h05};
    mem[1] = {O_LDI, 3'd2, 8'h03};
    mem[2] = {O_ADD, 3'd1, 3'd2, 5'd0};
    put_dump(3);
    run_program(0, 12, 5);

    // R3=0; DEC -> 0xFFFF; MOV R1,R3; INC R1 -> 0 with C=Z=1; JZ 0x20
    clear_mem();
    mem[0] = {O_LDI, 3'd3, 8'h00};
    mem[1] = {O_DEC, 3'd3, 8'h00};
    mem[2] = {O_MOV, 3'd1, 3'd3, 5'd0};
    mem[3] = {O_INC, 3'd1, 8'h00};
    mem[4] = {O_JZ, 3'd0, 8'h20};
    put_dump(8'h20);
    run_program(0, 'h29, 5);

    // CMP equal values, JC not taken, JZ taken; zero-wait then 3-wait fetches
    for (int w = 0; w < 2; w++) begin
      clear_mem();
      mem[0] = {O_LDI, 3'd1, 8'h05};
      mem[1] = {O_LDI, 3'd2, 8'h05};
      mem[2] = {O_CMP, 3'd1, 3'd2, 5'd0};
      mem[3] = {O_JC, 3'd0, 8'h40};
      mem[4] = {O_JZ, 3'd0, 8'h08};
      put_dump(8);
      run_program(w, 17, 5);
    end

    // Build 0x8000, SUB with borrow, AND keeps C=1 and sets N
    clear_mem();
    mem[0] = {O_LDI, 3'd1, 8'h80};
    for (int i = 1; i <= 8; i++) mem[i] = {O_ADD, 3'd1, 3'd1, 5'd0};
    mem[9]  = {O_LDI, 3'd2, 8'h01};
    mem[10] = {O_LDI, 3'd3, 8'h02};
    mem[11] = {O_SUB, 3'd2, 3'd3, 5'd0};
    mem[12] = {O_AND, 3'd1, 3'd1, 5'd0};
    mem[13] = {O_JC, 3'd0, 8'h20};
    mem[8'h20] = {O_JN, 3'd0, 8'h30};
    put_dump(8'h30);
    run_program(2, 'h39, 5);

    // HLT at 0x07 after NOP/undefined/MOV/OR; long idle afterwards
    clear_mem();
    mem[0] = {O_LDI, 3'd4, 8'h5A};
    mem[1] = {O_NOP, 3'd2, 8'hA7};
    mem[2] = {5'h0C, 3'd4, 8'h13};
    mem[3] = {O_MOV, 3'd5, 3'd4, 5'd0};
    mem[4] = {O_OR, 3'd5, 3'd4, 5'd0};
    mem[5] = {5'h1D, 3'd1, 8'h02};
    mem[6] = {O_NOP, 11'd0};
    mem[7] = {O_HLT, 11'd0};
    run_program(2, 8, 30);

    // Asynchronous reset while an ALU issue is in progress
    gen_random(30);
    mon_on    = 0;
    rst       = 1;
    wait_mode = 0;
    @(negedge clk);
    run_model();
    rst    = 0;
    mon_on = 1;
    cyc    = 0;
    while (alu_en !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("exec_reached", 32'(alu_en), 32'(1));
    mon_on = 0;
    rst    = 1;
    #1;
    chk("async_rst_alu_en", 32'(alu_en), 32'(0));
    chk("async_rst_pc", 32'(pc), 32'(0));
    chk("async_rst_imem_req", 32'(imem_req), 32'(0));
    chk("async_rst_alu_a", 32'(alu_a), 32'(0));
    clear_mem();
    put_dump(0);
    run_program(0, 9, 10);

    // Random programs with forward-only jumps and mixed wait states
    for (int t = 0; t < 25; t++) begin
      gen_random(int'($urandom_range(10, 40)));
      run_program(t % 3, -1, 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
